// File: rtl/stack_seq_if.sv
// Command handshake and stack-control bundle between decode, stack_seq and the operand stack.
interface stack_seq_if;
    localparam int unsigned DW  = 16;
    localparam int unsigned OPW = 4;

    logic           cmd_valid;
    logic           cmd_ready;
    logic [OPW-1:0] cmd_op;
    logic [DW-1:0]  cmd_arg;
    logic           done;
    logic           stk_push;
    logic           stk_pop;
    logic           stk_load;
    logic [DW-1:0]  stk_data_in;
    logic [DW-1:0]  stk_data0;
    logic [DW-1:0]  stk_data1;

    modport master (
        output cmd_valid, cmd_op, cmd_arg, stk_data0, stk_data1,
        input  cmd_ready, done, stk_push, stk_pop, stk_load, stk_data_in
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, stk_data0, stk_data1,
        output cmd_ready, done, stk_push, stk_pop, stk_load, stk_data_in
    );
endinterface

// File: rtl/stack_seq.sv
// stack_seq: multi-cycle command sequencer driving the 16-bit operand stack.
// Define STACK_SEQ_ARITH_EN to enable ADD/SUB (opcodes 8/9); otherwise they are illegal.
module stack_seq #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    stack_seq_if.slave                 bus,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       empty,
    output logic                       full,
    output logic                       err_ovf,
    output logic                       err_unf,
    output logic                       err_ill,
    input  logic                       err_clr
);
    localparam int unsigned DW      = 16;
    localparam int unsigned DEPTH_W = $clog2(DEPTH + 1);

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_PUSH  = 4'd1;
    localparam logic [3:0] OP_DROP  = 4'd2;
    localparam logic [3:0] OP_SET   = 4'd3;
    localparam logic [3:0] OP_DUP   = 4'd4;
    localparam logic [3:0] OP_SWAP  = 4'd5;
    localparam logic [3:0] OP_POPN  = 4'd6;
    localparam logic [3:0] OP_CLEAR = 4'd7;
`ifdef STACK_SEQ_ARITH_EN
    localparam logic [3:0] OP_ADD   = 4'd8;
    localparam logic [3:0] OP_SUB   = 4'd9;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWAP2 = 2'd1,
        S_POPN  = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [DEPTH_W-1:0] depth_nxt;
    logic [DEPTH_W-1:0] cnt_q, cnt_nxt;
    logic [DW-1:0]      d1_q, d1_nxt;
    logic               unf_pend_q, unf_pend_nxt;
    logic               done_nxt;
    logic               ovf_set_c, unf_set_c, ill_set_c;
    logic [DEPTH_W-1:0] popn_cnt_c;
    logic               popn_unf_c;
    logic [DW-1:0]      depth_ext;

    assign depth_ext     = DW'(depth);
    assign bus.cmd_ready = (state == S_IDLE);

    // Stack controls, next state and error detection
    always_comb begin
        bus.stk_push    = 1'b0;
        bus.stk_pop     = 1'b0;
        bus.stk_load    = 1'b0;
        bus.stk_data_in = '0;
        state_nxt       = state;
        depth_nxt       = depth;
        cnt_nxt         = cnt_q;
        d1_nxt          = d1_q;
        unf_pend_nxt    = unf_pend_q;
        done_nxt        = 1'b0;
        ovf_set_c       = 1'b0;
        unf_set_c       = 1'b0;
        ill_set_c       = 1'b0;
        popn_cnt_c      = '0;
        popn_unf_c      = 1'b0;
        if (!rst) begin
            case (state)
                S_IDLE: if (bus.cmd_valid) begin
                    done_nxt = 1'b1;
                    case (bus.cmd_op)
                        OP_NOP: ;
                        OP_PUSH: begin
                            bus.stk_push    = 1'b1;
                            bus.stk_load    = 1'b1;
                            bus.stk_data_in = bus.cmd_arg;
                            if (full) ovf_set_c = 1'b1;
                            else      depth_nxt = depth + DEPTH_W'(1);
                        end
                        OP_DROP: begin
                            if (empty) unf_set_c = 1'b1;
                            else begin
                                bus.stk_pop = 1'b1;
                                depth_nxt   = depth - DEPTH_W'(1);
                            end
                        end
                        OP_SET: begin
                            if (empty) unf_set_c = 1'b1;
                            else begin
                                bus.stk_load    = 1'b1;
                                bus.stk_data_in = bus.cmd_arg;
                            end
                        end
                        OP_DUP: begin
                            if (empty) unf_set_c = 1'b1;
                            else begin
                                bus.stk_push    = 1'b1;
                                bus.stk_load    = 1'b1;
                                bus.stk_data_in = bus.stk_data0;
                                if (full) ovf_set_c = 1'b1;
                                else      depth_nxt = depth + DEPTH_W'(1);
                            end
                        end
                        OP_SWAP: begin
                            if (depth_ext < DW'(2)) unf_set_c = 1'b1;
                            else begin
                                // Overwrite d1 with d0 now, push the saved d1 back next cycle
                                bus.stk_pop     = 1'b1;
                                bus.stk_load    = 1'b1;
                                bus.stk_data_in = bus.stk_data0;
                                d1_nxt          = bus.stk_data1;
                                state_nxt       = S_SWAP2;
                                done_nxt        = 1'b0;
                            end
                        end
                        OP_POPN, OP_CLEAR: begin
                            if (bus.cmd_op == OP_CLEAR || bus.cmd_arg >= depth_ext)
                                popn_cnt_c = depth;
                            else
                                popn_cnt_c = DEPTH_W'(bus.cmd_arg);
                            popn_unf_c = (bus.cmd_op == OP_POPN) && (bus.cmd_arg > depth_ext);
                            if (popn_cnt_c == '0) unf_set_c = popn_unf_c;
                            else begin
                                cnt_nxt      = popn_cnt_c;
                                unf_pend_nxt = popn_unf_c;
                                state_nxt    = S_POPN;
                                done_nxt     = 1'b0;
                            end
                        end
`ifdef STACK_SEQ_ARITH_EN
                        OP_ADD, OP_SUB: begin
                            if (depth_ext < DW'(2)) unf_set_c = 1'b1;
                            else begin
                                bus.stk_pop     = 1'b1;
                                bus.stk_load    = 1'b1;
                                bus.stk_data_in = (bus.cmd_op == OP_ADD)
                                                ? DW'(bus.stk_data0 + bus.stk_data1)
                                                : DW'(bus.stk_data1 - bus.stk_data0);
                                depth_nxt       = depth - DEPTH_W'(1);
                            end
                        end
`endif
                        default: ill_set_c = 1'b1;
                    endcase
                end
                S_SWAP2: begin
                    bus.stk_push    = 1'b1;
                    bus.stk_load    = 1'b1;
                    bus.stk_data_in = d1_q;
                    state_nxt       = S_IDLE;
                    done_nxt        = 1'b1;
                end
                S_POPN: begin
                    bus.stk_pop = 1'b1;
                    depth_nxt   = depth - DEPTH_W'(1);
                    cnt_nxt     = cnt_q - DEPTH_W'(1);
                    if (cnt_q == DEPTH_W'(1)) begin
                        state_nxt = S_IDLE;
                        done_nxt  = 1'b1;
                        unf_set_c = unf_pend_q;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // State, occupancy, done pulse and sticky error flags; a new error beats err_clr
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            depth      <= '0;
            empty      <= 1'b1;
            full       <= 1'b0;
            cnt_q      <= '0;
            d1_q       <= '0;
            unf_pend_q <= 1'b0;
            bus.done   <= 1'b0;
            err_ovf    <= 1'b0;
            err_unf    <= 1'b0;
            err_ill    <= 1'b0;
        end else begin
            state      <= state_nxt;
            depth      <= depth_nxt;
            empty      <= (depth_nxt == '0);
            full       <= (depth_nxt == DEPTH_W'(DEPTH));
            cnt_q      <= cnt_nxt;
            d1_q       <= d1_nxt;
            unf_pend_q <= unf_pend_nxt;
            bus.done   <= done_nxt;
            err_ovf    <= ovf_set_c | (err_ovf & ~err_clr);
            err_unf    <= unf_set_c | (err_unf & ~err_clr);
            err_ill    <= ill_set_c | (err_ill & ~err_clr);
        end
    end
endmodule

// File: tb/tb_stack_seq.sv
// Bench for stack_seq: behavioural operand stack plus a queue-based command model.
module tb_stack_seq;
    localparam int unsigned DEPTH   = 3;
    localparam int unsigned DEPTH_W = $clog2(DEPTH + 1);

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_PUSH  = 4'd1;
    localparam logic [3:0] OP_DROP  = 4'd2;
    localparam logic [3:0] OP_SET   = 4'd3;
    localparam logic [3:0] OP_DUP   = 4'd4;
    localparam logic [3:0] OP_SWAP  = 4'd5;
    localparam logic [3:0] OP_POPN  = 4'd6;
    localparam logic [3:0] OP_CLEAR = 4'd7;
    localparam logic [3:0] OP_ADD   = 4'd8;
    localparam logic [3:0] OP_SUB   = 4'd9;

    logic               clk = 1'b0;
    logic               rst;
    logic               err_clr;
    logic [DEPTH_W-1:0] depth;
    logic               empty, full, err_ovf, err_unf, err_ill;

    stack_seq_if bus();

    stack_seq #(.DEPTH(DEPTH)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .depth   (depth),
        .empty   (empty),
        .full    (full),
        .err_ovf (err_ovf),
        .err_unf (err_unf),
        .err_ill (err_ill),
        .err_clr (err_clr)
    );

    always #5 clk = ~clk;

    // Operand stack device controlled by the DUT
    logic [15:0] smem [DEPTH];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) smem[i] <= '0;
        end else if (bus.stk_push && bus.stk_load) begin
            smem[0] <= bus.stk_data_in;
            for (int i = 1; i < DEPTH; i++) smem[i] <= smem[i-1];
        end else if (bus.stk_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) smem[i] <= smem[i+1];
            smem[DEPTH-1] <= '0;
            if (bus.stk_load) smem[0] <= bus.stk_data_in;
        end else if (bus.stk_load) begin
            smem[0] <= bus.stk_data_in;
        end
    end
    assign bus.stk_data0 = smem[0];
    assign bus.stk_data1 = smem[1];

    // Reference model: front of queue is the top of stack
    logic [15:0] ref_q [$];
    logic        r_ovf, r_unf, r_ill;
    int          n_err    = 0;
    int          n_checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic ref_reset();
        ref_q.delete();
        r_ovf = 1'b0;
        r_unf = 1'b0;
        r_ill = 1'b0;
    endtask

    task automatic ref_push(input logic [15:0] v);
        ref_q.push_front(v);
        if (ref_q.size() > DEPTH) begin
            void'(ref_q.pop_back());
            r_ovf = 1'b1;
        end
    endtask

    task automatic ref_apply(input logic [3:0] op, input logic [15:0] arg, input logic clr,
                             output int lat);
        int          n;
        logic [15:0] a, b;
        lat = 1;
        if (clr) begin
            r_ovf = 1'b0;
            r_unf = 1'b0;
            r_ill = 1'b0;
        end
        case (op)
            OP_NOP:  ;
            OP_PUSH: ref_push(arg);
            OP_DROP: if (ref_q.size() == 0) r_unf = 1'b1; else void'(ref_q.pop_front());
            OP_SET:  if (ref_q.size() == 0) r_unf = 1'b1; else ref_q[0] = arg;
            OP_DUP:  if (ref_q.size() == 0) r_unf = 1'b1; else ref_push(ref_q[0]);
            OP_SWAP: begin
                if (ref_q.size() < 2) r_unf = 1'b1;
                else begin
                    a = ref_q[0];
                    ref_q[0] = ref_q[1];
                    ref_q[1] = a;
                    lat = 2;
                end
            end
            OP_POPN, OP_CLEAR: begin
                if (op == OP_CLEAR) n = ref_q.size();
                else begin
                    n = (int'(arg) < ref_q.size()) ? int'(arg) : ref_q.size();
                    if (int'(arg) > ref_q.size()) r_unf = 1'b1;
                end
                repeat (n) void'(ref_q.pop_front());
                lat = (n == 0) ? 1 : n + 1;
            end
`ifdef STACK_SEQ_ARITH_EN
            OP_ADD, OP_SUB: begin
                if (ref_q.size() < 2) r_unf = 1'b1;
                else begin
                    a = ref_q.pop_front();
                    b = ref_q.pop_front();
                    ref_q.push_front((op == OP_ADD) ? 16'(a + b) : 16'(b - a));
                end
            end
`endif
            default: r_ill = 1'b1;
        endcase
    endtask

    task automatic check_state(input string pfx);
        chk({pfx, "_depth"}, 32'(depth), 32'(ref_q.size()));
        chk({pfx, "_empty"}, 32'(empty), 32'(ref_q.size() == 0));
        chk({pfx, "_full"},  32'(full),  32'(ref_q.size() == DEPTH));
        chk({pfx, "_ovf"},   32'(err_ovf), 32'(r_ovf));
        chk({pfx, "_unf"},   32'(err_unf), 32'(r_unf));
        chk({pfx, "_ill"},   32'(err_ill), 32'(r_ill));
        if (ref_q.size() >= 1) chk({pfx, "_d0"}, 32'(bus.stk_data0), 32'(ref_q[0]));
        if (ref_q.size() >= 2) chk({pfx, "_d1"}, 32'(bus.stk_data1), 32'(ref_q[1]));
    endtask

    // Issue one command, wait (bounded) for done, compare timing and state to the model
    task automatic do_cmd(input logic [3:0] op, input logic [15:0] arg, input logic clr);
        int   exp_lat, lat, busy;
        logic seen;
        @(negedge clk);
        chk("ready", 32'(bus.cmd_ready), 32'd1);
        chk("done_pulse", 32'(bus.done), 32'd0);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_arg   = arg;
        err_clr       = clr;
        ref_apply(op, arg, clr, exp_lat);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        err_clr       = 1'b0;
        seen = 1'b0;
        lat  = 0;
        busy = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                lat  = i;
                break;
            end
            if (!bus.cmd_ready) busy++;
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("busy", 32'(busy), 32'(exp_lat - 1));
        check_state($sformatf("op%0d", op));
    endtask

    task automatic clear_err();
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        r_ovf = 1'b0;
        r_unf = 1'b0;
        r_ill = 1'b0;
        @(negedge clk);
        check_state("clr");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0]  op;
        logic [15:0] arg;
        logic        clr;

        rst           = 1'b1;
        err_clr       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_arg   = '0;
        ref_reset();
        repeat (2) @(negedge clk);

        chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_done",  32'(bus.done), 32'd0);
        chk("rst_push",  32'(bus.stk_push), 32'd0);
        chk("rst_pop",   32'(bus.stk_pop), 32'd0);
        chk("rst_load",  32'(bus.stk_load), 32'd0);
        chk("rst_din",   32'(bus.stk_data_in), 32'd0);
        check_state("rst");
        rst = 1'b0;

        do_cmd(OP_PUSH, 16'hCAFE, 1'b0);
        do_cmd(OP_PUSH, 16'hDEAD, 1'b0);
        chk("tp_push_d0", 32'(bus.stk_data0), 32'hDEAD);
        chk("tp_push_d1", 32'(bus.stk_data1), 32'hCAFE);

        do_cmd(OP_SWAP, 16'h0000, 1'b0);
        chk("tp_swap_d0", 32'(bus.stk_data0), 32'hCAFE);
        chk("tp_swap_d1", 32'(bus.stk_data1), 32'hDEAD);
        chk("tp_swap_depth", 32'(depth), 32'd2);

        do_cmd(OP_CLEAR, 16'h0000, 1'b0);
        do_cmd(OP_PUSH, 16'h0001, 1'b0);
        do_cmd(OP_PUSH, 16'h0003, 1'b0);
        do_cmd(OP_ADD, 16'h0000, 1'b0);
`ifdef STACK_SEQ_ARITH_EN
        chk("tp_add_d0", 32'(bus.stk_data0), 32'h0004);
        chk("tp_add_depth", 32'(depth), 32'd1);
`else
        chk("tp_add_ill", 32'(err_ill), 32'd1);
        chk("tp_add_d0", 32'(bus.stk_data0), 32'h0003);
`endif
        clear_err();
        do_cmd(OP_CLEAR, 16'h0000, 1'b0);
        do_cmd(OP_PUSH, 16'h0001, 1'b0);
        do_cmd(OP_PUSH, 16'h0003, 1'b0);
        do_cmd(OP_SUB, 16'h0000, 1'b0);
`ifdef STACK_SEQ_ARITH_EN
        chk("tp_sub_d0", 32'(bus.stk_data0), 32'hFFFE);
`else
        chk("tp_sub_ill", 32'(err_ill), 32'd1);
        chk("tp_sub_d0", 32'(bus.stk_data0), 32'h0003);
`endif

        clear_err();
        do_cmd(OP_CLEAR, 16'h0000, 1'b0);
        for (int v = 1; v <= 4; v++) do_cmd(OP_PUSH, 16'(v), 1'b0);
        chk("tp_ovf_full", 32'(full), 32'd1);
        chk("tp_ovf_flag", 32'(err_ovf), 32'd1);
        chk("tp_ovf_d0", 32'(bus.stk_data0), 32'd4);
        chk("tp_ovf_d1", 32'(bus.stk_data1), 32'd3);
        clear_err();
        chk("tp_ovf_clr", 32'(err_ovf), 32'd0);

        do_cmd(OP_POPN, 16'd5, 1'b0);
        chk("tp_popn_depth", 32'(depth), 32'd0);
        chk("tp_popn_empty", 32'(empty), 32'd1);
        chk("tp_popn_unf", 32'(err_unf), 32'd1);

        // Reset in the SWAP2 cycle aborts the swap with no done
        do_cmd(OP_PUSH, 16'h1111, 1'b0);
        do_cmd(OP_PUSH, 16'h2222, 1'b0);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_SWAP;
        bus.cmd_arg   = '0;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("swap2_busy", 32'(bus.cmd_ready), 32'd0);
        rst = 1'b1;
        #1;
        ref_reset();
        chk("abort_ready", 32'(bus.cmd_ready), 32'd1);
        chk("abort_depth", 32'(depth), 32'd0);
        chk("abort_push", 32'(bus.stk_push), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("abort_done", 32'(bus.done), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("abort_done_post", 32'(bus.done), 32'd0);
        do_cmd(OP_PUSH, 16'hFACE, 1'b0);
        chk("tp_face_d0", 32'(bus.stk_data0), 32'hFACE);

        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 3) == 0) op = OP_PUSH;
            else                           op = 4'($urandom_range(0, 15));
            arg = (op == OP_POPN) ? 16'($urandom_range(0, 5)) : 16'($urandom);
            clr = ($urandom_range(0, 7) == 0);
            do_cmd(op, arg, clr);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/stack_seq.md
# stack_seq

Command sequencer for the 16-bit operand `stack`. It accepts one stack-machine command at a time over a valid/ready handshake and drives the stack's `push`, `pop`, `load` and `data_in` inputs, using multiple cycles where an operation needs them. It also keeps an occupancy count and sticky error flags. It sits between the CPU decode stage and the `stack` instance, and owns that stack's control inputs exclusively.

## Interface
- `DEPTH`, default 8: depth of the controlled `stack`; must equal the stack's `DEPTH`.
- `clk`  in  1  clock, rising-edge.
- `rst`  in  1  reset, asynchronous, active-high; the same net also resets the `stack`.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command.
- `cmd_op`  in  4  opcode: 0 NOP, 1 PUSH, 2 DROP, 3 SET, 4 DUP, 5 SWAP, 6 POPN, 7 CLEAR, 8 ADD, 9 SUB; 10–15 illegal.
- `cmd_arg`  in  16  immediate for PUSH/SET; count for POPN.
- `done`  out  1  one-cycle pulse after a command completes.
- `stk_push`, `stk_pop`, `stk_load`  out  1 each  stack controls.
- `stk_data_in`  out  16  stack write data.
- `stk_data0`, `stk_data1`  in  16 each  top and second stack entries.
- `depth`  out  $clog2(DEPTH+1)  valid entries, 0..DEPTH.
- `empty`, `full`  out  1 each  depth==0 and depth==DEPTH.
- `err_ovf`, `err_unf`, `err_ill`  out  1 each  sticky overflow, underflow and illegal-op flags.
- `err_clr`  in  1  clears all three error flags.

## Operation
- States: IDLE, SWAP2, POPN.
- `cmd_ready` = 1 only in IDLE. A command is accepted at a rising edge with `cmd_valid && cmd_ready`.
- Stack controls are combinational from the state and the accepted command. They default to 0, and `stk_data_in` defaults to 0.
- The stack semantics this block relies on:
  - push+load: data0 ← data_in, and the old entries shift down.
  - pop+load: the top is removed and the new top is replaced by data_in.
  - pop alone: the stack shifts up.
  - load alone: data0 ← data_in.
- Per-opcode behaviour:
  - NOP: no stack action; `done` is still pulsed.
  - PUSH: push+load, data_in = `cmd_arg`; depth+1.
  - DROP: pop; depth−1.
  - SET: load, data_in = `cmd_arg`; depth unchanged. Requires depth ≥ 1.
  - DUP: push+load, data_in = `stk_data0`; depth+1. Requires depth ≥ 1.
  - SWAP: two cycles, with d0/d1 latched at accept.
    - Accept cycle: pop+load, data_in = d0.
    - SWAP2 cycle: push+load, data_in = d1.
    - Net depth unchanged. Requires depth ≥ 2.
  - POPN: load an internal counter with min(`cmd_arg`, depth). Then pop once per cycle in the POPN state until the counter reaches 0.
    - `cmd_arg` = 0, or depth = 0 with `cmd_arg` = 0: completes with no pop.
    - `cmd_arg` > depth: pops every entry, then sets `err_unf`.
  - CLEAR: behaves as POPN with the count equal to depth; never raises an error.
  - ADD: pop+load, data_in = d0 + d1 (16-bit, carry discarded). Requires depth ≥ 2.
  - SUB: pop+load, data_in = d1 − d0 (16-bit, wraps). Requires depth ≥ 2.
- Error handling:
  - If a depth requirement is not met: no stack action, `err_unf` is set, and `done` is still pulsed.
  - DROP at depth 0: same handling as an unmet depth requirement (underflow, no pop).
  - PUSH/DUP at depth == DEPTH: the push is performed (the bottom entry is lost), `err_ovf` is set, and depth stays DEPTH.
  - Illegal opcode: no action, `err_ill` is set, `done` is pulsed.
- Error flags are set at the edge that detects the condition and hold until `err_clr`. If `err_clr` and a new error occur in the same cycle, the error wins.

## Timing
- Reset values: state IDLE, depth 0, `empty`=1, `full`=0, all error flags 0, `done`=0, `cmd_ready`=1. All `stk_*` outputs are 0.
- `rst` asserted in SWAP2 or POPN aborts the operation immediately; no `done` is issued.
- Single-cycle ops: the stack and depth update at the accept edge. `done` is high for the following cycle, in which `stk_data0`/`stk_data1` already show the result. The next command can be accepted in that same cycle.
- SWAP: `done` is high 2 cycles after accept.
- POPN: `done` is high N+1 cycles after accept, where N ≥ 1 is the number of pops. With 0 pops it is high 1 cycle after accept.
- `depth`, `empty`, `full` are registered and reflect all updates made up to the previous edge.

## Configuration
- `STACK_SEQ_ARITH_EN`: defined → ADD and SUB behave as specified above. Undefined → opcodes 8 and 9 are illegal (`err_ill`, no stack action) and the adder/subtractor is not built.

## Test plan
- DEPTH=3. PUSH 0xCAFE, PUSH 0xDEAD → after second `done`: data0=0xDEAD, data1=0xCAFE, depth=2.
- Next, SWAP → `cmd_ready` is low for 1 cycle; `done` arrives 2 cycles after accept with data0=0xCAFE, data1=0xDEAD, depth=2.
- With the stack holding 0x0003, 0x0001, ADD → data0=0x0004, depth=1. Repeat with SUB on 0x0001, 0x0003 (d1=0x0001, d0=0x0003) → data0=0xFFFE. With the macro undefined, both commands → `err_ill`=1 and data0 is unchanged.
- PUSH 1, 2, 3, then PUSH 4 → `full`=1, `err_ovf`=1, data0=4, data1=3, depth=3. Then `err_clr` → `err_ovf`=0.
- At depth 3, POPN with `cmd_arg`=5 → 3 pops on consecutive cycles, `done` 4 cycles after accept, depth=0, `empty`=1, `err_unf`=1.
- Assert `rst` during the SWAP2 cycle → `cmd_ready`=1, depth=0, no `done`. A PUSH 0xFACE afterwards works normally.
